// File: rtl/clk_div_multi_if.sv
// Tone write/sync bus into clk_div_multi.
// The sequencer drives it as master and the divider receives it as slave.
interface clk_div_multi_if #(
    parameter int CNT_W = 20
);
    logic             wr_en;
    logic [2:0]       wr_ch;
    logic [CNT_W-1:0] wr_half;
    logic             sync;

    modport master (output wr_en, wr_ch, wr_half, sync);
    modport slave  (input  wr_en, wr_ch, wr_half, sync);
endinterface

// File: rtl/clk_div_multi.sv
// Clock-division block with three parts:
// - a free-running cycle counter,
// - a 1 ms square wave with an aligned one-cycle tick,
// - NUM_CH tone channels. Each channel's half-period can be rewritten without glitches.

// One tone channel.
// A new half-period is held in nxt and only becomes active at a toggle
// boundary, so there are never any runt pulses.
module clk_div_tone_ch #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_hit,
    input  logic             sync,
    input  logic [CNT_W-1:0] wr_half,
    output logic             tone,
    output logic             pend
);
    logic [CNT_W-1:0] act, nxt, cnt;

    // Channel state:
    // - sync realigns the channel.
    // - A silent channel loads a pending value at once.
    // - A running channel swaps values only at a half-period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act  <= '0;
            nxt  <= '0;
            cnt  <= '0;
            tone <= 1'b0;
            pend <= 1'b0;
        end else if (sync) begin
            cnt  <= '0;
            tone <= 1'b0;
            if (wr_hit) begin
                act  <= wr_half;
                nxt  <= wr_half;
                pend <= 1'b0;
            end else if (pend) begin
                act  <= nxt;
                pend <= 1'b0;
            end
        end else begin
            if (act == '0) begin
                if (pend) begin
                    act  <= nxt;
                    cnt  <= '0;
                    pend <= 1'b0;
                end
            end else if (cnt == act - CNT_W'(1)) begin
                cnt <= '0;
                if (pend) begin
                    act  <= nxt;
                    pend <= 1'b0;
                    tone <= (nxt == '0) ? 1'b0 : ~tone;
                end else begin
                    tone <= ~tone;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // A write lands after any boundary swap above, so the last write wins.
            if (wr_hit) begin
                nxt  <= wr_half;
                pend <= 1'b1;
            end
        end
    end
endmodule

module clk_div_multi #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000,
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 20,
    parameter int DIV_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    clk_div_multi_if.slave     wr_bus,
    output logic [DIV_W-1:0]   div,
    output logic               clk_1ms,
    output logic               tick_1ms,
    output logic [NUM_CH-1:0]  tone,
    output logic [NUM_CH-1:0]  pend
);
    localparam int HALF = CLK_HZ / (2 * TICK_HZ);
    localparam int H_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [H_W-1:0] H_LAST = H_W'(HALF - 1);

    logic [H_W-1:0] h;

    // Free-running cycle counter; wraps naturally at 2^DIV_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div <= '0;
        else        div <= div + DIV_W'(1);
    end

    // 1 ms square wave. The tick fires on the same edge that clk_1ms rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h        <= '0;
            clk_1ms  <= 1'b0;
            tick_1ms <= 1'b0;
        end else if (h == H_LAST) begin
            h        <= '0;
            clk_1ms  <= ~clk_1ms;
            tick_1ms <= ~clk_1ms;
        end else begin
            h        <= h + H_W'(1);
            tick_1ms <= 1'b0;
        end
    end

    // One channel instance per tone. Writes to wr_ch >= NUM_CH match no channel.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_tone_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_hit  (wr_bus.wr_en && (wr_bus.wr_ch == 3'(c))),
            .sync    (wr_bus.sync),
            .wr_half (wr_bus.wr_half),
            .tone    (tone[c]),
            .pend    (pend[c])
        );
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with HALF=5, NUM_CH=2, CNT_W=8, DIV_W=4.
module tb_clk_div_multi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] div;
    logic       clk_1ms, tick_1ms;
    logic [1:0] tone, pend;
    int         n_chk = 0;
    int         n_err = 0;
    int         ecnt = 0;

    clk_div_multi_if #(.CNT_W(8)) wif ();

    clk_div_multi #(
        .CLK_HZ(100), .TICK_HZ(10), .NUM_CH(2), .CNT_W(8), .DIV_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_bus   (wif.slave),
        .div      (div),
        .clk_1ms  (clk_1ms),
        .tick_1ms (tick_1ms),
        .tone     (tone),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic wr(input int ch, input int half);
        wif.wr_en   = 1'b1;
        wif.wr_ch   = 3'(ch);
        wif.wr_half = 8'(half);
    endtask

    // One character per edge: the expected tone/pend values after that edge.
    task automatic ch_seq(input string tag, input string t0, input string p0,
                          input string t1, input string p1);
        for (int i = 0; i < t0.len(); i++) begin
            step();
            wif.wr_en = 1'b0;
            wif.sync  = 1'b0;
            chk($sformatf("%s tone0[%0d]", tag, i), 32'(tone[0]), 32'(t0[i] == "1"));
            chk($sformatf("%s pend0[%0d]", tag, i), 32'(pend[0]), 32'(p0[i] == "1"));
            chk($sformatf("%s tone1[%0d]", tag, i), 32'(tone[1]), 32'(t1[i] == "1"));
            chk($sformatf("%s pend1[%0d]", tag, i), 32'(pend[1]), 32'(p1[i] == "1"));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " div"},  32'(div),      32'd0);
        chk({tag, " c1ms"}, 32'(clk_1ms),  32'd0);
        chk({tag, " tick"}, 32'(tick_1ms), 32'd0);
        chk({tag, " tone"}, 32'(tone),     32'd0);
        chk({tag, " pend"}, 32'(pend),     32'd0);
    endtask

    initial begin
        bit found;
        wif.wr_en = 1'b0; wif.wr_ch = '0; wif.wr_half = '0; wif.sync = 1'b0;

        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Edge k after release:
        // - div = k mod 16,
        // - clk_1ms is high for k = 5..9, 15..19,
        // - tick_1ms fires at k = 5 and k = 15.
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("div@%0d", k),  32'(div),      32'(k % 16));
            chk($sformatf("c1ms@%0d", k), 32'(clk_1ms),  32'((k / 5) % 2));
            chk($sformatf("tick@%0d", k), 32'(tick_1ms), 32'(k % 10 == 5));
        end

        // Silent ch0 written with 3: tone rises at E+4, then toggles every 3 cycles.
        wr(0, 3);
        ch_seq("sil3", "00001110001", "10000000000", "00000000000", "00000000000");
        // Write 5 mid-half: the current 3-cycle half completes, then halves are 5 cycles.
        wr(0, 5);
        ch_seq("run5", "1100000111110", "1100000000000", "0000000000000", "0000000000000");
        // Write 0: at the boundary the tone stays low and the channel goes silent.
        wr(0, 0);
        ch_seq("mute", "000000000", "111100000", "000000000", "000000000");
        // Restart with 2 under the silent-channel rule.
        wr(0, 2);
        ch_seq("rst2", "00011001", "10000000", "00000000", "00000000");
        // ch1 gets 4 while silent; ch0 gets 3 while running at 2.
        wr(1, 4);
        ch_seq("ch1w", "1", "0", "0", "1");
        wr(0, 3);
        ch_seq("ch0w", "00111", "11000", "00001", "00000");
        // sync: both tones and counters clear, then rise after 3 and 4 cycles.
        wif.sync = 1'b1;
        ch_seq("sync", "000111000", "000000000", "000011110", "000000000");
        // sync together with a write to ch1: half=2 is active at once, with no pend.
        wif.sync = 1'b1;
        wr(1, 2);
        ch_seq("syncw", "00011", "00000", "00110", "00000");
        // An out-of-range channel changes nothing.
        wr(7, 9);
        ch_seq("ch7", "1000", "0000", "0110", "0000");

        // After the last sequence, ch0 runs at half=3 and is high on the edges
        // k=1..3, 7..9, ...
        // Find an edge where both tone0 and clk_1ms are high.
        found = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if ((ecnt % 10) >= 5 && ((k - 1) / 3) % 2 == 0) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_find", 32'(found), 32'd1);
        chk("pre_rst c1ms",  32'(clk_1ms), 32'd1);
        chk("pre_rst tone0", 32'(tone[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        #1;
        rst_n = 1'b1;
        ecnt = 0;
        repeat (5) step();
        chk("rerun c1ms", 32'(clk_1ms),  32'd1);
        chk("rerun tick", 32'(tick_1ms), 32'd1);
        chk("rerun div",  32'(div),      32'd5);
        chk("rerun tone", 32'(tone),     32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
